mips_pipeline_fwd: RTL and testbench

Single-clock, parametrised successor of the two-phase MIPS32 pipeline core: same five stages (IF, ID, EX, MEM, WB), same opcode set and instruction encoding. Adds full operand forwarding, load-use hazard stalling, branch flushing, a synchronous reset, a program/data load port and debug observability. Data width and memory depths are parameters. It is the execution core that test programs run on.

---
 rtl/mips_pipeline_fwd.sv | 192 +++++++++++++++++++
 tb/tb_mips_pipeline_fwd.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_fwd.sv
// mips_pipeline_fwd: single-clock five-stage MIPS32-subset core (IF ID EX MEM WB)
// with full EX operand forwarding, one-cycle load-use stall, branch resolution in EX
// (two-cycle flush), HLT freeze, a reset-time memory load port and a debug register read.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   ld_en/ld_sel     load-port strobe (only while rst=1) and target (0 imem, 1 dmem)
//   ld_addr/ld_data  load-port word address and data
//   dbg_raddr        debug register index; dbg_rdata is a combinational read of it
//   halted           set once HLT (or an invalid opcode) retires
//   retire_cnt       number of retired non-HLT instructions
module mips_pipeline_fwd #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned DMEM_AW = 10,
  localparam int unsigned LD_AW  = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [LD_AW-1:0] ld_addr,
  input  logic [31:0]      ld_data,
  input  logic [4:0]       dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata,
  output logic             halted,
  output logic [31:0]      retire_cnt
);
  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03,
                         OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09,
                         OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C,
                         OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E;

  logic [31:0]        imem [2**IMEM_AW];
  logic [XLEN-1:0]    dmem [2**DMEM_AW];
  logic [XLEN-1:0]    regs [32];

  logic [IMEM_AW-1:0] pc;
  logic               fetch_stop;
  // IF/ID
  logic               fd_valid;
  logic [31:0]        fd_ir;
  logic [IMEM_AW-1:0] fd_pc;
  // ID/EX
  logic               de_valid, de_hlt;
  logic [5:0]         de_op;
  logic [4:0]         de_rs, de_rt, de_dst;
  logic [XLEN-1:0]    de_a, de_b, de_imm;
  logic [IMEM_AW-1:0] de_pc;
  // EX/MEM
  logic               em_valid, em_hlt, em_lw, em_sw;
  logic [4:0]         em_dst;
  logic [XLEN-1:0]    em_res, em_sd;
  // MEM/WB
  logic               mw_valid, mw_hlt;
  logic [4:0]         mw_dst;
  logic [XLEN-1:0]    mw_val;

  // Decode of the instruction in ID; non-writing ops get destination 0
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_dst;
  logic            id_rr, id_iop, id_br, id_halt, id_uses_rt;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            mw_wr;

  assign id_op      = fd_ir[31:26];
  assign id_rs      = fd_ir[25:21];
  assign id_rt      = fd_ir[20:16];
  assign id_rr      = (id_op <= OP_MUL);
  assign id_iop     = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
  assign id_br      = (id_op == OP_BEQZ) || (id_op == OP_BNEQZ);
  assign id_halt    = fd_valid && !(id_rr || id_iop || id_br || id_op == OP_LW || id_op == OP_SW);
  assign id_uses_rt = id_rr || id_br || (id_op == OP_SW);
  assign id_dst     = id_rr ? fd_ir[15:11] : ((id_iop || id_op == OP_LW) ? id_rt : 5'd0);
  assign id_imm     = XLEN'($signed(fd_ir[15:0]));

  // Register read with same-cycle WB bypass; R0 is never written so it reads 0
  assign mw_wr = mw_valid && !mw_hlt && (mw_dst != 5'd0);
  assign id_a  = (mw_wr && mw_dst == id_rs) ? mw_val : regs[id_rs];
  assign id_b  = (mw_wr && mw_dst == id_rt) ? mw_val : regs[id_rt];

  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  // EX operand forwarding: EX/MEM (non-load) beats MEM/WB beats ID/EX copy
  logic            em_fwd;
  logic [XLEN-1:0] ex_a, ex_b, ex_res;
  logic            ex_taken, ld_stall;
  logic [IMEM_AW-1:0] ex_target;

  assign em_fwd = em_valid && !em_lw && !em_hlt && (em_dst != 5'd0);
  assign ex_a = (em_fwd && em_dst == de_rs) ? em_res : ((mw_wr && mw_dst == de_rs) ? mw_val : de_a);
  assign ex_b = (em_fwd && em_dst == de_rt) ? em_res : ((mw_wr && mw_dst == de_rt) ? mw_val : de_b);

  // ALU; loads and stores compute the effective address
  always_comb begin
    ex_res = '0;
    case (de_op)
      OP_ADD:               ex_res = ex_a + ex_b;
      OP_SUB:               ex_res = ex_a - ex_b;
      OP_AND:               ex_res = ex_a & ex_b;
      OP_OR:                ex_res = ex_a | ex_b;
      OP_SLT:               ex_res[0] = ($signed(ex_a) < $signed(ex_b));
      OP_MUL:               ex_res = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + de_imm;
      OP_SUBI:              ex_res = ex_a - de_imm;
      OP_SLTI:              ex_res[0] = ($signed(ex_a) < $signed(de_imm));
      default:              ex_res = '0;
    endcase
  end

  assign ex_taken  = de_valid && (((de_op == OP_BEQZ) && (ex_a == '0)) ||
                                  ((de_op == OP_BNEQZ) && (ex_a != '0)));
  assign ex_target = de_pc + IMEM_AW'(1) + IMEM_AW'(de_imm);
  // A taken branch flush overrides the load-use stall
  assign ld_stall  = !ex_taken && de_valid && (de_op == OP_LW) && fd_valid &&
                     ((id_rs == de_dst) || (id_uses_rt && id_rt == de_dst));

  // Memories: load port during reset, stores from MEM otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_en && !ld_sel) imem[IMEM_AW'(ld_addr)] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_en && ld_sel) dmem[DMEM_AW'(ld_addr)] <= XLEN'(ld_data);
    end else if (!halted && em_valid && em_sw) begin
      dmem[DMEM_AW'(em_res)] <= em_sd;
    end
  end

  // Pipeline, register file and status; everything freezes once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      fd_valid   <= 1'b0;
      de_valid   <= 1'b0;
      em_valid   <= 1'b0;
      mw_valid   <= 1'b0;
      halted     <= 1'b0;
      retire_cnt <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted) begin
      // WB
      if (mw_wr) regs[mw_dst] <= mw_val;
      if (mw_valid) begin
        if (mw_hlt) halted <= 1'b1;
        else        retire_cnt <= retire_cnt + 32'd1;
      end
      // MEM
      mw_valid <= em_valid;
      mw_hlt   <= em_hlt;
      mw_dst   <= em_dst;
      mw_val   <= em_lw ? dmem[DMEM_AW'(em_res)] : em_res;
      // EX
      em_valid <= de_valid && !ex_taken ? de_valid : de_valid;
      em_hlt   <= de_hlt;
      em_lw    <= (de_op == OP_LW);
      em_sw    <= (de_op == OP_SW);
      em_dst   <= de_dst;
      em_res   <= ex_res;
      em_sd    <= ex_b;
      // ID
      de_valid <= fd_valid && !ex_taken && !ld_stall;
      de_hlt   <= id_halt;
      de_op    <= id_op;
      de_rs    <= id_rs;
      de_rt    <= id_rt;
      de_dst   <= id_dst;
      de_a     <= id_a;
      de_b     <= id_b;
      de_imm   <= id_imm;
      de_pc    <= fd_pc;
      // IF
      if (ex_taken) begin
        pc       <= ex_target;
        fd_valid <= 1'b0;
      end else if (ld_stall) begin
        fd_valid <= fd_valid;
      end else if (fetch_stop || id_halt) begin
        fd_valid <= 1'b0;
      end else begin
        fd_valid <= 1'b1;
        fd_ir    <= imem[pc];
        fd_pc    <= pc;
        pc       <= pc + IMEM_AW'(1);
      end
      if (id_halt && !ex_taken) fetch_stop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_fwd.sv
// tb_mips_pipeline_fwd: directed programs on a 32-bit and a 16-bit core; expected
// architectural results are queued when each program is loaded and drained after it halts.
module tb_mips_pipeline_fwd;
  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A,
                         SUBI = 6'h0B, SLTI = 6'h0C, BNEQZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;
  localparam int unsigned K_REG = 0, K_HCYC = 1, K_RET = 2, K_MEM = 3, K_HALTED = 4, K_REG16 = 5;

  logic        clk = 1'b0;
  logic        rst, rst16, ld_en, ld_sel;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_raddr, dbg_raddr16;
  logic [31:0] dbg_rdata, retire_cnt, retire_cnt16;
  logic [15:0] dbg_rdata16;
  logic        halted, halted16;

  always #5 clk = ~clk;

  mips_pipeline_fwd dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .halted(halted), .retire_cnt(retire_cnt)
  );

  mips_pipeline_fwd #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst16), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_raddr(dbg_raddr16), .dbg_rdata(dbg_rdata16),
    .halted(halted16), .retire_cnt(retire_cnt16)
  );

  typedef struct {
    string       tag;
    int unsigned kind;
    int unsigned idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned hcyc;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  task automatic push(input string tag, input int unsigned kind, input int unsigned idx,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  // Optionally load prog during reset, release reset, count cycles until halted
  task automatic run(input bit w16, input bit do_load, input int unsigned budget);
    if (w16) rst16 = 1'b1; else rst = 1'b1;
    if (do_load) begin
      ld_en = 1'b1; ld_sel = 1'b0;
      foreach (prog[i]) begin
        ld_addr = 10'(i);
        ld_data = prog[i];
        @(posedge clk); #1;
      end
      ld_en = 1'b0;
    end
    @(posedge clk); #1;
    if (w16) rst16 = 1'b0; else rst = 1'b0;
    hcyc = 0;
    for (int c = 1; c <= int'(budget); c++) begin
      @(posedge clk); #1;
      if ((w16 ? halted16 : halted) === 1'b1) begin
        hcyc = c;
        break;
      end
    end
  endtask

  // Pop every queued expectation and compare against the DUT's state
  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG:    begin dbg_raddr = 5'(e.idx); #1; obs = dbg_rdata; end
        K_REG16:  begin dbg_raddr16 = 5'(e.idx); #1; obs = 32'(dbg_rdata16); end
        K_HCYC:   obs = 32'(hcyc);
        K_RET:    obs = retire_cnt;
        K_MEM:    obs = dut.dmem[e.idx];
        default:  obs = 32'(halted);
      endcase
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst16 = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    dbg_raddr = '0; dbg_raddr16 = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_halted", K_HALTED, 0, 32'd0);
    push("rst_retire", K_RET, 0, 32'd0);
    push("rst_r5", K_REG, 5, 32'd0);
    drain();

    // Forwarding from EX/MEM and MEM/WB, back to back
    prog = {enc_i(ADDI, 0, 1, 16'd10), enc_i(ADDI, 0, 2, 16'd20), enc_r(ADD, 1, 2, 3),
            enc_i(HLT, 0, 0, 16'd0)};
    push("fwd_r1", K_REG, 1, 32'd10);
    push("fwd_r2", K_REG, 2, 32'd20);
    push("fwd_r3", K_REG, 3, 32'd30);
    push("fwd_hcyc", K_HCYC, 0, 32'd8);
    push("fwd_retire", K_RET, 0, 32'd3);
    run(1'b0, 1'b1, 100);
    drain();

    // Store, load and immediate use of the load result (one stall)
    prog = {enc_i(ADDI, 0, 1, 16'd7), enc_i(SW, 0, 1, 16'd5), enc_i(LW, 0, 2, 16'd5),
            enc_r(ADD, 2, 2, 3), enc_i(HLT, 0, 0, 16'd0)};
    push("lu_r2", K_REG, 2, 32'd7);
    push("lu_r3", K_REG, 3, 32'd14);
    push("lu_mem5", K_MEM, 5, 32'd7);
    push("lu_hcyc", K_HCYC, 0, 32'd10);
    push("lu_retire", K_RET, 0, 32'd4);
    run(1'b0, 1'b1, 100);
    drain();

    // Taken branch squashes the two following instructions
    prog = {enc_i(BEQZ, 0, 0, 16'd2), enc_i(ADDI, 0, 4, 16'd1), enc_i(ADDI, 0, 5, 16'd1),
            enc_i(ADDI, 0, 6, 16'd9), enc_i(HLT, 0, 0, 16'd0)};
    push("br_r4", K_REG, 4, 32'd0);
    push("br_r5", K_REG, 5, 32'd0);
    push("br_r6", K_REG, 6, 32'd9);
    push("br_hcyc", K_HCYC, 0, 32'd9);
    push("br_retire", K_RET, 0, 32'd2);
    run(1'b0, 1'b1, 100);
    drain();

    // Countdown loop; HLT after the branch is killed on every taken iteration
    prog = {enc_i(ADDI, 0, 1, 16'd5), enc_i(ADDI, 0, 2, 16'd0), enc_i(ADDI, 2, 2, 16'd3),
            enc_i(SUBI, 1, 1, 16'd1), enc_i(BNEQZ, 1, 0, 16'hFFFD), enc_i(HLT, 0, 0, 16'd0)};
    push("loop_r1", K_REG, 1, 32'd0);
    push("loop_r2", K_REG, 2, 32'd15);
    push("loop_halted", K_HALTED, 0, 32'd1);
    push("loop_retire", K_RET, 0, 32'd17);
    run(1'b0, 1'b1, 200);
    drain();

    // Invalid opcode halts; later instruction never executes
    prog = {32'h8000_0000, enc_i(ADDI, 0, 7, 16'd1)};
    push("inv_hcyc", K_HCYC, 0, 32'd5);
    push("inv_halted", K_HALTED, 0, 32'd1);
    push("inv_r7", K_REG, 7, 32'd0);
    push("inv_retire", K_RET, 0, 32'd0);
    run(1'b0, 1'b1, 100);
    repeat (3) @(posedge clk);
    #1;
    push("frozen_halted", K_HALTED, 0, 32'd1);
    drain();

    // Reset while halted clears status; program restarts from address 0
    rst = 1'b1;
    @(posedge clk); #1;
    push("rsthalt_halted", K_HALTED, 0, 32'd0);
    push("rsthalt_retire", K_RET, 0, 32'd0);
    drain();
    push("restart_hcyc", K_HCYC, 0, 32'd5);
    push("restart_r7", K_REG, 7, 32'd0);
    run(1'b0, 1'b0, 100);
    drain();

    // 16-bit datapath: wraparound and signed compares
    prog = {enc_i(ADDI, 0, 1, 16'hFFFF), enc_i(ADDI, 1, 1, 16'd2), enc_i(SLTI, 1, 2, 16'hFFFF),
            enc_i(ADDI, 0, 3, 16'hFFFF), enc_i(SLTI, 3, 4, 16'd0), enc_r(SUB, 0, 1, 5),
            enc_i(HLT, 0, 0, 16'd0)};
    push("x16_r1", K_REG16, 1, 32'h0001);
    push("x16_r2", K_REG16, 2, 32'h0000);
    push("x16_r3", K_REG16, 3, 32'hFFFF);
    push("x16_r4", K_REG16, 4, 32'h0001);
    push("x16_r5", K_REG16, 5, 32'hFFFF);
    run(1'b1, 1'b1, 100);
    vectors++;
    assert (halted16 === 1'b1) else begin
      miscompares++;
      $error("FAIL x16_halted: observed %0b expected 1", halted16);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
